// File: rtl/dsp_mac_sequencer.sv
// rtl/dsp_mac_sequencer.sv - operand sequencer and result capture for a DSP48A1 MAC slice
module dsp_mac_sequencer #(
  parameter int N_TAPS   = 8,
  parameter int P_LAT    = 3,
  parameter int OP_ALIGN = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [17:0] IN_A,
  input  logic [17:0] IN_B,
  output logic [17:0] DSP_A,
  output logic [17:0] DSP_B,
  output logic [7:0]  DSP_OPMODE,
  input  logic [47:0] DSP_P,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [47:0] OUT_DATA,
  output logic        BUSY
);

  // count must hold N_TAPS; drain counter must hold P_LAT+1 (it steps once more on the capture edge)
  localparam int CNT_W = $clog2(N_TAPS + 1);
  localparam int DRN_W = $clog2(P_LAT + 2);

  localparam logic [CNT_W-1:0] TAPS_C    = CNT_W'(N_TAPS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [DRN_W-1:0] DRAIN_END = DRN_W'(P_LAT);
  localparam logic [DRN_W-1:0] DRN_ONE   = DRN_W'(1);

  // X=M, Z=0: starts a new sum. X=M, Z=P: adds the product (or 0 for a bubble) to P.
  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]      count_q, count_d;
  logic [DRN_W-1:0]      drain_q, drain_d;
  logic [17:0]           dsp_a_q, dsp_a_d;
  logic [17:0]           dsp_b_q, dsp_b_d;
  logic [OP_ALIGN:0][7:0] op_pipe_q;
  logic [7:0]            opmode_d;
  logic [47:0]           out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  logic in_ready;
  logic busy;
  logic capture;
  logic in_xfer;
  logic out_xfer;
  logic last_pair;
  logic drain_done;

  assign in_xfer    = IN_VALID & in_ready;
  assign out_xfer   = out_valid_q & OUT_READY;
  assign last_pair  = ((count_q + CNT_ONE) == TAPS_C);
  assign drain_done = (drain_q == DRAIN_END);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: frame accumulates, waits out the slice pipeline, then holds the result
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_xfer) begin
          state_d = last_pair ? S_DRAIN : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_xfer && last_pair) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_done) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_xfer) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs; ready never looks at IN_VALID, only the FIRST opcode does
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    capture  = 1'b0;
    opmode_d = OPM_ACC;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (IN_VALID) begin
          opmode_d = OPM_FIRST;
        end
      end
      S_ACCUM: begin
        in_ready = 1'b1;
      end
      S_DRAIN: begin
        capture = drain_done;
      end
      S_HOLD: begin
        capture = 1'b0;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Datapath next-state: issue pair or zero bubble, tap/drain counting, result capture
  always_comb begin
    count_d     = count_q;
    drain_d     = drain_q;
    dsp_a_d     = '0;
    dsp_b_d     = '0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (in_xfer) begin
      count_d = count_q + CNT_ONE;
      dsp_a_d = IN_A;
      dsp_b_d = IN_B;
    end else if (out_xfer) begin
      count_d = '0;
    end

    if (in_xfer && last_pair) begin
      drain_d = '0;
    end else if (state_q == S_DRAIN) begin
      drain_d = drain_q + DRN_ONE;
    end

    if (capture) begin
      out_data_d  = DSP_P;
      out_valid_d = 1'b1;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q     <= '0;
      drain_q     <= '0;
      dsp_a_q     <= '0;
      dsp_b_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      drain_q     <= drain_d;
      dsp_a_q     <= dsp_a_d;
      dsp_b_q     <= dsp_b_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // OPMODE is registered with its pair, then delayed to match the slice's A/B register stage
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_pipe_q <= '0;
    end else begin
      op_pipe_q[0] <= opmode_d;
      for (int i = 1; i <= OP_ALIGN; i++) begin
        op_pipe_q[i] <= op_pipe_q[i-1];
      end
    end
  end

  assign IN_READY   = in_ready;
  assign BUSY       = busy;
  assign DSP_A      = dsp_a_q;
  assign DSP_B      = dsp_b_q;
  assign DSP_OPMODE = op_pipe_q[OP_ALIGN];
  assign OUT_VALID  = out_valid_q;
  assign OUT_DATA   = out_data_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb/tb_dsp_mac_sequencer.sv - directed and random checks of dsp_mac_sequencer with a slice model
module tb_dsp_mac_sequencer;

  localparam int N  = 4;
  localparam int PL = 3;
  localparam int OA = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [17:0] in_a, in_b, dsp_a, dsp_b;
  logic [7:0]  dsp_opmode;
  logic [47:0] dsp_p, out_data;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [17:0] in_a1, in_b1, dsp_a1, dsp_b1;
  logic [7:0]  dsp_opmode1;
  logic [47:0] dsp_p1, out_data1;

  dsp_mac_sequencer #(.N_TAPS(N), .P_LAT(PL), .OP_ALIGN(OA)) dut (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_A(in_a), .IN_B(in_b), .DSP_A(dsp_a), .DSP_B(dsp_b),
    .DSP_OPMODE(dsp_opmode), .DSP_P(dsp_p), .OUT_VALID(out_valid),
    .OUT_READY(out_ready), .OUT_DATA(out_data), .BUSY(busy)
  );

  dsp_mac_sequencer #(.N_TAPS(1), .P_LAT(PL), .OP_ALIGN(OA)) dut1 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid1), .IN_READY(in_ready1),
    .IN_A(in_a1), .IN_B(in_b1), .DSP_A(dsp_a1), .DSP_B(dsp_b1),
    .DSP_OPMODE(dsp_opmode1), .DSP_P(dsp_p1), .OUT_VALID(out_valid1),
    .OUT_READY(out_ready1), .OUT_DATA(out_data1), .BUSY(busy1)
  );

  // DSP48A1 behaviour: A1/B1 reg, M reg, OPMODE reg, P reg
  logic [17:0] s0_a, s0_b, s1_a, s1_b;
  logic [35:0] s0_m, s1_m;
  logic [7:0]  s0_op, s1_op;
  logic [47:0] s0_p, s1_p;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_a <= '0; s0_b <= '0; s0_m <= '0; s0_op <= '0; s0_p <= '0;
      s1_a <= '0; s1_b <= '0; s1_m <= '0; s1_op <= '0; s1_p <= '0;
    end else begin
      s0_a <= dsp_a; s0_b <= dsp_b; s0_m <= s0_a * s0_b; s0_op <= dsp_opmode;
      s0_p <= ((s0_op[1:0] == 2'b01) ? {12'h0, s0_m} : 48'h0) + ((s0_op[3:2] == 2'b10) ? s0_p : 48'h0);
      s1_a <= dsp_a1; s1_b <= dsp_b1; s1_m <= s1_a * s1_b; s1_op <= dsp_opmode1;
      s1_p <= ((s1_op[1:0] == 2'b01) ? {12'h0, s1_m} : 48'h0) + ((s1_op[3:2] == 2'b10) ? s1_p : 48'h0);
    end
  end
  assign dsp_p  = s0_p;
  assign dsp_p1 = s1_p;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = 0;

  // Reference model of dut (N taps): frame sums, handshake windows, opcode history
  int          nacc;
  logic        pending;
  logic        ov_exp;
  int          drain_left;
  logic [47:0] run_sum;
  logic [47:0] res_exp;
  logic [7:0]  hist[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    nacc = 0; pending = 1'b0; ov_exp = 1'b0; drain_left = 0;
    run_sum = '0; res_exp = '0;
    hist.delete();
    repeat (OA) hist.push_back(8'h00);
  endtask

  task automatic tick();
    logic        xfer, oxfer;
    logic [17:0] a, b;
    logic [7:0]  code;
    chk("in_ready", 64'(in_ready), 64'(!pending));
    chk("busy", 64'(busy), 64'(pending || nacc != 0));
    xfer  = in_valid && !pending;
    oxfer = ov_exp && out_ready;
    a = in_a; b = in_b;
    code = (xfer && nacc == 0) ? 8'h01 : 8'h09;
    @(posedge clk); #1;
    cyc++;
    if (oxfer) begin ov_exp = 1'b0; pending = 1'b0; end
    if (drain_left > 0) begin
      drain_left--;
      if (drain_left == 0) ov_exp = 1'b1;
    end
    if (xfer) begin
      run_sum += 48'(a) * 48'(b);
      nacc++;
      if (nacc == N) begin
        pending = 1'b1; drain_left = PL + 1; res_exp = run_sum;
        run_sum = '0; nacc = 0; last_acc = cyc;
      end
    end
    hist.push_back(code);
    chk("dsp_a", 64'(dsp_a), 64'(xfer ? a : 18'h0));
    chk("dsp_b", 64'(dsp_b), 64'(xfer ? b : 18'h0));
    chk("dsp_opmode", 64'(dsp_opmode), 64'(hist[hist.size()-1-OA]));
    while (hist.size() > OA) void'(hist.pop_front());
    chk("out_valid", 64'(out_valid), 64'(ov_exp));
    if (ov_exp) chk("out_data", 64'(out_data), 64'(res_exp));
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_a = 18'($urandom);
    in_b = 18'($urandom);
  endtask

  task automatic send(input logic [17:0] a, input logic [17:0] b);
    int n;
    n = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    while (in_ready !== 1'b1 && n < 60) begin tick(); n++; end
    chk("send_ready_timeout", 64'(in_ready), 64'(1));
    tick();
    idle_inputs();
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin tick(); n++; end
    chk("out_valid_timeout", 64'(out_valid), 64'(1));
  endtask

  task automatic reset_checks(input string pfx);
    chk({pfx, "_dsp_a"}, 64'(dsp_a), 64'(0));
    chk({pfx, "_dsp_b"}, 64'(dsp_b), 64'(0));
    chk({pfx, "_dsp_opmode"}, 64'(dsp_opmode), 64'(0));
    chk({pfx, "_out_data"}, 64'(out_data), 64'(0));
    chk({pfx, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({pfx, "_busy"}, 64'(busy), 64'(0));
    chk({pfx, "_in_ready"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; out_ready1 = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst");
    chk("rst_dut1_valid", 64'(out_valid1), 64'(0));
    chk("rst_dut1_busy", 64'(busy1), 64'(0));
    rst_n = 1'b1;

    // back-to-back frame, consumer always ready
    out_ready = 1'b1;
    send(1, 2); send(3, 4); send(5, 6); send(7, 8);
    wait_valid();
    chk("t1_latency", 64'(cyc - last_acc), 64'(PL + 1));
    chk("t1_result", 64'(out_data), 64'(100));
    tick();
    chk("t1_valid_one_cycle", 64'(out_valid), 64'(0));

    // two-cycle input gap between pairs 2 and 3
    send(1, 2); send(3, 4);
    tick(); tick();
    send(5, 6); send(7, 8);
    wait_valid();
    chk("t2_result", 64'(out_data), 64'(100));
    tick();

    // held result with backpressure, then a second frame with no carry-over
    out_ready = 1'b0;
    repeat (4) send(1, 1);
    wait_valid();
    chk("t3_first_result", 64'(out_data), 64'(4));
    in_valid = 1'b1; in_a = 18'd2; in_b = 18'd3;
    repeat (5) begin
      tick();
      chk("t3_hold_data", 64'(out_data), 64'(4));
      chk("t3_hold_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    repeat (4) send(2, 3);
    wait_valid();
    chk("t3_second_result", 64'(out_data), 64'(24));
    tick();

    // largest operands
    repeat (4) send(18'h3FFFF, 18'h3FFFF);
    wait_valid();
    chk("t4_max_result", 64'(out_data), 64'(48'h3F_FFE0_0004));
    tick();

    // single-tap instance goes straight to DRAIN
    out_ready1 = 1'b1;
    in_valid1 = 1'b1; in_a1 = 18'd100; in_b1 = 18'd200;
    chk("t5_ready_idle", 64'(in_ready1), 64'(1));
    tick();
    in_valid1 = 1'b0; in_a1 = 18'($urandom); in_b1 = 18'($urandom);
    chk("t5_busy", 64'(busy1), 64'(1));
    chk("t5_ready_drain", 64'(in_ready1), 64'(0));
    chk("t5_dsp_a", 64'(dsp_a1), 64'(100));
    chk("t5_dsp_b", 64'(dsp_b1), 64'(200));
    tick();
    chk("t5_opmode_first", 64'(dsp_opmode1), 64'(8'h01));
    chk("t5_bubble_a", 64'(dsp_a1), 64'(0));
    chk("t5_valid_early2", 64'(out_valid1), 64'(0));
    tick();
    chk("t5_valid_early3", 64'(out_valid1), 64'(0));
    tick();
    chk("t5_valid_early4", 64'(out_valid1), 64'(0));
    tick();
    chk("t5_valid", 64'(out_valid1), 64'(1));
    chk("t5_result", 64'(out_data1), 64'(20000));
    tick();
    chk("t5_valid_drop", 64'(out_valid1), 64'(0));
    chk("t5_idle_busy", 64'(busy1), 64'(0));
    chk("t5_idle_ready", 64'(in_ready1), 64'(1));

    // reset in the middle of a frame
    send(1, 2); send(3, 4);
    rst_n = 1'b0;
    #2;
    reset_checks("t6");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    chk("t6_ready_after", 64'(in_ready), 64'(1));
    send(1, 2); send(3, 4); send(5, 6); send(7, 8);
    wait_valid();
    chk("t6_result", 64'(out_data), 64'(100));
    tick();

    // random traffic and random backpressure against the model
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = 18'($urandom);
      in_b      = 18'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    idle_inputs();
    out_ready = 1'b1;
    while (nacc != 0) send(18'($urandom), 18'($urandom));
    for (int i = 0; i < 40 && pending; i++) tick();
    tick();
    chk("final_busy", 64'(busy), 64'(0));
    chk("final_valid", 64'(out_valid), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
